// File: rtl/data_ram_responder.sv
// Byte-addressed little-endian data RAM answering MEM-stage loads/stores after a fixed wait latency.
// Define MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors instead of aligning them.
module data_ram_responder #(
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_se,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic [31:0]       rdata,
   output logic              resp_valid,
   output logic              resp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              rw;
      logic [1:0]        size;
      logic              se;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   req_t              live, lat, cur;
   logic              accept, enter_resp, err, we, err_q;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] a [4];
   logic [7:0]        b [4];
   logic [31:0]       ld_data;
   logic [2:0]        nb;
   logic [31:0]       rdata_q;
   logic [7:0]        mem [2**ADDR_W];

   assign live = '{rw: req_rw, size: req_size, se: req_se, addr: req_addr, wdata: req_wdata};
   assign accept = req_valid && req_ready;

   // cnt holds the cycles left until RESP; LATENCY == 1 skips WAIT entirely
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= 4'(LATENCY - 1);
         else if (state == WAIT)
            cnt <= cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd1) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE) && !reset;
      resp_valid = (state == RESP) && !reset;
   end

   always_ff @(posedge clk) begin
      if (accept) lat <= live;
   end

   // With LATENCY == 1 the RESP edge is the acceptance edge, so use the live request there
   assign cur        = (state == IDLE) ? live : lat;
   assign enter_resp = (state_nxt == RESP) && !reset;

   always_comb begin
      base = cur.addr;
      err  = (cur.size == 2'b11);
`ifdef MISALIGN_CHECK_EN
      if (cur.size == 2'b01 && cur.addr[0])         err = 1'b1;
      if (cur.size == 2'b10 && cur.addr[1:0] != 2'b00) err = 1'b1;
`else
      if (cur.size == 2'b01) base[0]   = 1'b0;
      if (cur.size == 2'b10) base[1:0] = 2'b00;
`endif
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         a[k] = base + ADDR_W'(k);
         b[k] = mem[a[k]];
      end
      case (cur.size)
         2'b00:   ld_data = {{24{cur.se & b[0][7]}}, b[0]};
         2'b01:   ld_data = {{16{cur.se & b[1][7]}}, b[1], b[0]};
         default: ld_data = {b[3], b[2], b[1], b[0]};
      endcase
      case (cur.size)
         2'b00:   nb = 3'd1;
         2'b01:   nb = 3'd2;
         default: nb = 3'd4;
      endcase
   end

   assign we = enter_resp && cur.rw && !err;

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (we && 3'(k) < nb) mem[a[k]] <= cur.wdata[8*k +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         err_q <= err;
         if (err)
            rdata_q <= '0;
         else if (!cur.rw)
            rdata_q <= ld_data;
      end
   end

   assign rdata    = rdata_q;
   assign resp_err = err_q && resp_valid;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_data_ram_responder;
   localparam int AW  = 9;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_rw, req_se;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata, rdata;
   logic          resp_valid, resp_err;

   logic          v1, rdy1, rw1, rv1, re1;
   logic [31:0]   wd1, rd1;

   always #5 clk = ~clk;

   data_ram_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_rw(req_rw), .req_size(req_size), .req_se(req_se), .req_addr(req_addr),
      .req_wdata(req_wdata), .rdata(rdata), .resp_valid(resp_valid), .resp_err(resp_err)
   );

   data_ram_responder #(.ADDR_W(AW), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
      .req_rw(rw1), .req_size(2'b10), .req_se(1'b0), .req_addr(9'h004),
      .req_wdata(wd1), .rdata(rd1), .resp_valid(rv1), .resp_err(re1)
   );

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0, n_fail = 0, n_resp = 0, cyc = 0, last_acc = 0;
   logic [31:0] last_rd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (resp_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_resp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("latency#%0d", n_resp), 32'(cyc - e.acc), 32'(LAT));
            chk($sformatf("resp_err#%0d", n_resp), {31'd0, resp_err}, {31'd0, e.err});
            chk($sformatf("rdata#%0d", n_resp), rdata, e.rd);
            n_resp++;
         end
      end
   end

   // Called at a negedge; returns at the negedge after acceptance with req_valid still high
   task automatic send(input logic rw, input logic [1:0] sz, input logic se,
                       input logic [AW-1:0] ad, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input bit push);
      exp_t e;
      int   n;
      req_valid = 1'b1; req_rw = rw; req_size = sz; req_se = se;
      req_addr = ad; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      last_acc = cyc;
      if (push) begin
         e.err = e_err;
         if (e_err)   e.rd = '0;
         else if (rw) e.rd = last_rd;
         else         e.rd = e_rd;
         last_rd = e.rd;
         e.acc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic st(input logic [1:0] sz, input logic [AW-1:0] ad, input logic [31:0] wd);
      send(1'b1, sz, 1'b0, ad, wd, 1'b0, '0, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic ld(input logic [1:0] sz, input logic se, input logic [AW-1:0] ad,
                     input logic [31:0] exp);
      send(1'b0, sz, se, ad, 32'h0, 1'b0, exp, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic l1_req(input logic rw, input logic [31:0] wd, input logic [31:0] exp);
      int n = 0;
      v1 = 1'b1; rw1 = rw; wd1 = wd;
      while (!rdy1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      v1 = 1'b0;
      n = 1;
      while (!rv1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("lat1_latency", 32'(n), 32'd1);
      chk("lat1_err", {31'd0, re1}, 32'd0);
      if (!rw) chk("lat1_rdata", rd1, exp);
      @(negedge clk);
   endtask

   initial begin
      int a0;
      reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_se = 1'b0;
      req_addr = '0; req_wdata = '0; v1 = 1'b0; rw1 = 1'b0; wd1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ready1", {31'd0, rdy1}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      st(2'b10, 9'h010, 32'hDEADBEEF);
      ld(2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
      ld(2'b00, 1'b0, 9'h010, 32'h000000EF);
      st(2'b00, 9'h020, 32'h00000080);
      ld(2'b00, 1'b1, 9'h020, 32'hFFFFFF80);
      ld(2'b00, 1'b0, 9'h020, 32'h00000080);
      st(2'b01, 9'h022, 32'h00008001);
      ld(2'b01, 1'b1, 9'h022, 32'hFFFF8001);
      ld(2'b01, 1'b0, 9'h022, 32'h00008001);

      // req_valid held high across three loads
      st(2'b10, 9'h050, 32'h55667788);
      send(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
      a0 = last_acc;
      chk("ready_in_wait", {31'd0, req_ready}, 32'd0);
      send(1'b0, 2'b00, 1'b0, 9'h020, 32'h0, 1'b0, 32'h00000080, 1'b1);
      chk("b2b_gap1", 32'(last_acc - a0), 32'(LAT + 1));
      a0 = last_acc;
      send(1'b0, 2'b10, 1'b0, 9'h050, 32'h0, 1'b0, 32'h55667788, 1'b1);
      chk("b2b_gap2", 32'(last_acc - a0), 32'(LAT + 1));
      req_valid = 1'b0;

      // request fields change while in WAIT
      send(1'b0, 2'b10, 1'b0, 9'h050, 32'h0, 1'b0, 32'h55667788, 1'b1);
      req_valid = 1'b0; req_addr = 9'h010; req_size = 2'b00; req_rw = 1'b1;

      st(2'b10, 9'h030, 32'hCAFEF00D);
      send(1'b1, 2'b11, 1'b0, 9'h030, 32'hFFFFFFFF, 1'b1, '0, 1'b1);
      req_valid = 1'b0;
      ld(2'b10, 1'b0, 9'h030, 32'hCAFEF00D);
      send(1'b0, 2'b11, 1'b0, 9'h030, 32'h0, 1'b1, '0, 1'b1);
      req_valid = 1'b0;
`ifdef MISALIGN_CHECK_EN
      send(1'b0, 2'b10, 1'b0, 9'h031, 32'h0, 1'b1, '0, 1'b1);
      req_valid = 1'b0;
`else
      ld(2'b10, 1'b0, 9'h031, 32'hCAFEF00D);
`endif

      // reset lands during WAIT of a store
      st(2'b10, 9'h040, 32'h11223344);
      send(1'b1, 2'b10, 1'b0, 9'h040, 32'h12345678, 1'b0, '0, 1'b0);
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_rdata", rdata, 32'd0);
      last_rd = '0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
      ld(2'b10, 1'b0, 9'h040, 32'h11223344);

      st(2'b10, 9'h1FC, 32'hA1B2C3D4);
      ld(2'b00, 1'b0, 9'h1FC, 32'h000000D4);
      ld(2'b00, 1'b0, 9'h1FD, 32'h000000C3);
      ld(2'b00, 1'b0, 9'h1FE, 32'h000000B2);
      ld(2'b00, 1'b0, 9'h1FF, 32'h000000A1);
      wait_drain();

      l1_req(1'b1, 32'h01020304, '0);
      l1_req(1'b0, 32'h0, 32'h01020304);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
